// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 selector family: default lane width and lane indices.
package mux_pkg;
    localparam int DEFAULT_WIDTH = 1;
    localparam int LANE0         = 0;
    localparam int LANE1         = 1;
endpackage

// File: rtl/mux2x1_sel.sv
// Purely combinational 2:1 lane selector over a packed two-lane input bus.
module mux2x1_sel
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] din,
    input  logic               sel,
    output logic [WIDTH-1:0]   dout
);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;

    assign lane0 = din[LANE0*WIDTH +: WIDTH];
    assign lane1 = din[LANE1*WIDTH +: WIDTH];

    // A plain conditional keeps X on sel visible rather than masking it.
    assign dout = sel ? lane1 : lane0;

endmodule

// File: rtl/mux2x1_reg.sv
// 2:1 selector with a combinational output and a single-entry valid/ready output register.
module mux2x1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] din,
    input  logic               sel,
    output logic [WIDTH-1:0]   dout_comb,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;
    logic             out_valid_d;
    logic             out_valid_q;
    logic             accept;

    mux2x1_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .din  (din),
        .sel  (sel),
        .dout (sel_data)
    );

    assign dout_comb = sel_data;

    // The slot is free when empty or when its occupant leaves this same edge.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            dout_d      = sel_data;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2x1_reg.sv
// Randomised and directed scoreboard bench for mux2x1_reg (WIDTH=8 handshake, WIDTH=1 selector).
module tb_mux2x1_reg;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2*W-1:0] din = '0;
    logic           sel = 1'b0;
    logic [W-1:0]   dout_comb;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   dout;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic [1:0] din1 = '0;
    logic       sel1 = 1'b0;
    logic       dout_comb1;
    logic       in_ready1;
    logic       dout1;
    logic       out_valid1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_dout = '0;
    bit           model_valid = 1'b0;

    always #5 clk = ~clk;

    mux2x1_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .dout_comb (dout_comb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux2x1_reg #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din1),
        .sel       (sel1),
        .dout_comb (dout_comb1),
        .in_valid  (1'b0),
        .in_ready  (in_ready1),
        .dout      (dout1),
        .out_valid (out_valid1),
        .out_ready (1'b1)
    );

    function automatic logic [W-1:0] pick(input logic [2*W-1:0] d, input logic s);
        int unsigned v;
        v = (int'(d) >> (s ? W : 0)) % 256;
        return v[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transfer attempt: inputs change on the falling edge, the model books the accept on the rising edge.
    task automatic drive(input bit iv, input logic [2*W-1:0] d, input bit s, input bit ordy);
        bit acc;
        @(negedge clk);
        in_valid  = iv;
        din       = d;
        sel       = s;
        out_ready = ordy;
        acc = iv && (!model_valid || ordy);
        @(posedge clk);
        if (acc) begin
            exp_q.push_back(pick(d, s));
            model_valid = 1'b1;
        end else if (ordy) begin
            model_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_valid = 1'b0;
        last_dout = '0;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        #1;
        din = 16'hC3E7;
        sel = 1'b1;
        #1;
        chk("rst_dout_comb", 32'(dout_comb), 32'hC3);
        rst_n = 1'b1;
    endtask

    // Monitor: checks the settled outputs just after inputs change, pops on each downstream transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("dout_comb", 32'(dout_comb), 32'(pick(din, sel)));
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("dout", 32'(dout), 32'(exp_q[0]));
                if (out_ready) begin
                    last_dout = exp_q.pop_front();
                end
            end else if (!out_valid) begin
                chk("dout_hold", 32'(dout), 32'(last_dout));
            end
        end
    end

    initial begin
        logic [1:0] pat[6];
        logic       psel[6];
        logic       pexp[6];
        int         wait_cnt;
        pat  = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
        psel = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pexp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        #1;
        chk("por_dout", 32'(dout), 32'h0);
        chk("por_out_valid", 32'(out_valid), 32'h0);
        chk("por_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            din1 = pat[i];
            sel1 = psel[i];
            #1;
            chk("w1_dout_comb", 32'(dout_comb1), 32'(pexp[i]));
            #9;
        end
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 16'hA55A, 1'b0, 1'b1);
        drive(1'b1, 16'hA55A, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1);
        drive(1'b0, 16'h5555, 1'b0, 1'b1);
        drive(1'b0, 16'h5555, 1'b1, 1'b1);
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        drive(1'b0, 16'h1234, 1'b1, 1'b0);
        pulse_reset();
        drive(1'b1, 16'h7E81, 1'b0, 1'b0);
        drive(1'b0, 16'h7E81, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 3) != 0), 16'($urandom), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 2) != 0));
            if (i == 200) pulse_reset();
        end

        wait_cnt = 0;
        while (model_valid && wait_cnt < 10) begin
            drive(1'b0, 16'h0, 1'b0, 1'b1);
            wait_cnt++;
        end
        @(negedge clk);
        #3;
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("final_out_valid", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
